// File: rtl/ln_pkg.sv
// Shared definitions for the local-network psum router.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: mode_t (BUS=0, CHAIN=1), default psum geometry.
package ln_pkg;

   // Routing mode of the router: BUS sends local psums to the shared bus,
   // CHAIN hands them straight back to the local PE.
   typedef enum logic {
      MODE_BUS   = 1'b0,
      MODE_CHAIN = 1'b1
   } mode_t;

   localparam int DATA_SIZE_DEF = 16;
   localparam int PSUM_NUM_DEF  = 4;

endpackage

// File: rtl/ln_fifo.sv
// Synchronous FIFO holding outgoing psum transfers.
// Latency: 1 cycle push-to-head (head is read from registered storage).
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, rst (async, active-high); push/push_data; pop; head (current
//        entry, stale when empty); full; empty; count (occupancy 0..DEPTH).
module ln_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ln_router.sv
// Local-network psum router: buffers local psums and routes them to the PE
// (CHAIN) or to the shared bus (BUS), with a drain-before-switch mode change.
// Latency: 1 cycle opsum-to-output via FIFO; bus-to-PE path is combinational.
// Backpressure: opsum_ready low when FIFO full or a mode change is pending.
// Ports: clk, rst; set_info/connect_flag/cfg_busy (config); opsum_* (from PE);
//        ipsum_* (to PE); ipsum_bus_* (from bus); opsum_bus_* (to bus);
//        fifo_count (occupancy).
module ln_router
   import ln_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int PSUM_NUM  = PSUM_NUM_DEF,
   parameter int DEPTH     = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            set_info,
   input  logic                            connect_flag,
   output logic                            cfg_busy,
   input  logic [PSUM_NUM*DATA_SIZE-1:0]   opsum_data,
   input  logic                            opsum_valid,
   output logic                            opsum_ready,
   output logic [PSUM_NUM*DATA_SIZE-1:0]   ipsum_data,
   output logic                            ipsum_valid,
   input  logic                            ipsum_ready,
   input  logic [PSUM_NUM*DATA_SIZE-1:0]   ipsum_bus_data,
   input  logic                            ipsum_bus_valid,
   output logic                            ipsum_bus_ready,
   output logic [PSUM_NUM*DATA_SIZE-1:0]   opsum_bus_data,
   output logic                            opsum_bus_valid,
   input  logic                            opsum_bus_ready,
   output logic [$clog2(DEPTH):0]          fifo_count
);

   localparam int W = PSUM_NUM * DATA_SIZE;

   mode_t          mode_q;
   mode_t          pend_q;
   logic           busy_q;
   logic           fifo_full;
   logic           fifo_empty;
   logic [W-1:0]   fifo_head;
   logic           fifo_push;
   logic           fifo_pop;

   assign cfg_busy    = busy_q;
   assign opsum_ready = !fifo_full && !busy_q;
   assign fifo_push   = opsum_valid && opsum_ready;
   // Pop decision uses the registered empty flag, so an entry pushed into an
   // empty FIFO can never leave in the same cycle.
   assign fifo_pop    = !fifo_empty &&
                        ((mode_q == MODE_CHAIN) ? ipsum_ready : opsum_bus_ready);

   ln_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (opsum_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Mode change: set_info records the request and holds off new pushes;
   // the switch happens only once the FIFO has drained under the old mode.
   // A fresh set_info always wins over completion so a late request is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_BUS;
         pend_q <= MODE_BUS;
         busy_q <= 1'b0;
      end else if (set_info) begin
         pend_q <= mode_t'(connect_flag);
         busy_q <= 1'b1;
      end else if (busy_q && fifo_empty) begin
         mode_q <= pend_q;
         busy_q <= 1'b0;
      end
   end

   // Output steering; every data bus is zeroed while its valid is low.
   always_comb begin
      ipsum_valid     = 1'b0;
      ipsum_data      = '0;
      ipsum_bus_ready = 1'b0;
      opsum_bus_valid = 1'b0;
      opsum_bus_data  = '0;
      if (mode_q == MODE_CHAIN) begin
         ipsum_valid = !fifo_empty;
         if (!fifo_empty) ipsum_data = fifo_head;
      end else begin
         opsum_bus_valid = !fifo_empty;
         if (!fifo_empty) opsum_bus_data = fifo_head;
         ipsum_valid     = ipsum_bus_valid;
         if (ipsum_bus_valid) ipsum_data = ipsum_bus_data;
         ipsum_bus_ready = ipsum_ready;
      end
   end

endmodule

// File: tb/tb_ln_router.sv
// Testbench for ln_router: directed scenarios followed by randomized traffic
// checked against a queue-based reference model.
module tb_ln_router;
   import ln_pkg::*;

   localparam int DEPTH = 4;
   localparam int W     = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          set_info;
   logic          connect_flag;
   logic          cfg_busy;
   logic [W-1:0]  opsum_data;
   logic          opsum_valid;
   logic          opsum_ready;
   logic [W-1:0]  ipsum_data;
   logic          ipsum_valid;
   logic          ipsum_ready;
   logic [W-1:0]  ipsum_bus_data;
   logic          ipsum_bus_valid;
   logic          ipsum_bus_ready;
   logic [W-1:0]  opsum_bus_data;
   logic          opsum_bus_valid;
   logic          opsum_bus_ready;
   logic [2:0]    fifo_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ln_router #(.DATA_SIZE(16), .PSUM_NUM(4), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .set_info        (set_info),
      .connect_flag    (connect_flag),
      .cfg_busy        (cfg_busy),
      .opsum_data      (opsum_data),
      .opsum_valid     (opsum_valid),
      .opsum_ready     (opsum_ready),
      .ipsum_data      (ipsum_data),
      .ipsum_valid     (ipsum_valid),
      .ipsum_ready     (ipsum_ready),
      .ipsum_bus_data  (ipsum_bus_data),
      .ipsum_bus_valid (ipsum_bus_valid),
      .ipsum_bus_ready (ipsum_bus_ready),
      .opsum_bus_data  (opsum_bus_data),
      .opsum_bus_valid (opsum_bus_valid),
      .opsum_bus_ready (opsum_bus_ready),
      .fifo_count      (fifo_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [W-1:0] a_val, e0, e1, f_val;
      logic [W-1:0] q[$];
      logic         m_chain, m_busy, m_pend;
      logic         e_rdy, do_push, do_pop;
      int           acc, sz0;

      rst = 1'b1; set_info = 0; connect_flag = 0;
      opsum_data = '0; opsum_valid = 0; ipsum_ready = 0;
      ipsum_bus_data = '0; ipsum_bus_valid = 0; opsum_bus_ready = 0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_ordy", opsum_ready, 1);
      chk("rst_obv", opsum_bus_valid, 0);
      chk("rst_ipv", ipsum_valid, 0);

      // BUS mode: local push appears on the bus one cycle later.
      a_val = 64'h0001_0002_0003_0004;
      opsum_bus_ready = 1; opsum_valid = 1; opsum_data = a_val;
      #1;
      chk("bus_same_cycle_obv", opsum_bus_valid, 0);
      tick();
      opsum_valid = 0; opsum_data = '0;
      #1;
      chk("bus_obv", opsum_bus_valid, 1);
      chk("bus_obd", opsum_bus_data, a_val);
      chk("bus_ipv_quiet", ipsum_valid, 0);
      tick();
      #1;
      chk("bus_obv_after_pop", opsum_bus_valid, 0);
      chk("bus_obd_zero", opsum_bus_data, 0);

      // BUS mode: bus psum passes combinationally to the PE.
      ipsum_bus_valid = 1; ipsum_bus_data = 64'h55; ipsum_ready = 0;
      #1;
      chk("pass_ipv", ipsum_valid, 1);
      chk("pass_ipd", ipsum_data, 64'h55);
      chk("pass_ibr0", ipsum_bus_ready, 0);
      ipsum_ready = 1;
      #1;
      chk("pass_ibr1", ipsum_bus_ready, 1);
      ipsum_bus_valid = 0; ipsum_bus_data = '0; ipsum_ready = 0;
      #1;
      chk("pass_ipd_zero", ipsum_data, 0);

      // Fill: 5 attempts against a 4-deep FIFO, then drain in order.
      opsum_bus_ready = 0; acc = 0;
      for (int i = 0; i < 5; i++) begin
         opsum_valid = 1; opsum_data = 64'h100 + 64'(i);
         #1;
         if (opsum_ready) acc++;
         tick();
      end
      opsum_valid = 0;
      #1;
      chk("fill_accepted", 64'(acc), 4);
      chk("fill_count", fifo_count, 4);
      chk("fill_ordy", opsum_ready, 0);
      opsum_bus_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_obv", opsum_bus_valid, 1);
         chk("drain_obd", opsum_bus_data, 64'h100 + 64'(i));
         tick();
      end
      #1;
      chk("drain_count", fifo_count, 0);

      // Mode switch BUS->CHAIN waits for the two queued entries to drain.
      opsum_bus_ready = 0;
      e0 = 64'hAAAA_0000_0000_0001; e1 = 64'hBBBB_0000_0000_0002;
      opsum_valid = 1; opsum_data = e0; tick();
      opsum_data = e1; tick();
      opsum_valid = 0;
      set_info = 1; connect_flag = 1; tick();
      set_info = 0; connect_flag = 0;
      #1;
      chk("sw_busy", cfg_busy, 1);
      chk("sw_ordy", opsum_ready, 0);
      opsum_bus_ready = 1;
      #1;
      chk("sw_d0", opsum_bus_data, e0);
      tick();
      #1;
      chk("sw_busy_mid", cfg_busy, 1);
      chk("sw_d1", opsum_bus_data, e1);
      tick();
      #1;
      chk("sw_busy_empty", cfg_busy, 1);
      chk("sw_ordy_empty", opsum_ready, 0);
      tick();
      #1;
      chk("sw_busy_done", cfg_busy, 0);
      chk("sw_ordy_done", opsum_ready, 1);
      f_val = 64'hF00D_0000_0000_00FF;
      ipsum_ready = 0; opsum_valid = 1; opsum_data = f_val; tick();
      opsum_valid = 0;
      #1;
      chk("chain_ipv", ipsum_valid, 1);
      chk("chain_ipd", ipsum_data, f_val);
      chk("chain_obv", opsum_bus_valid, 0);
      chk("chain_ibr", ipsum_bus_ready, 0);
      ipsum_ready = 1; tick();
      #1;
      chk("chain_ipv_pop", ipsum_valid, 0);

      // Async reset with 3 entries queued clears without a clock edge.
      ipsum_ready = 0; opsum_valid = 1;
      for (int i = 0; i < 3; i++) begin
         opsum_data = 64'h300 + 64'(i); tick();
      end
      opsum_valid = 0;
      #1;
      chk("pre_rst_count", fifo_count, 3);
      #1;
      rst = 1;
      #1;
      chk("arst_count", fifo_count, 0);
      chk("arst_ipv", ipsum_valid, 0);
      chk("arst_obv", opsum_bus_valid, 0);
      chk("arst_busy", cfg_busy, 0);
      tick();
      rst = 0;

      // set_info(1) overwritten by set_info(0) while busy: stays BUS.
      opsum_bus_ready = 0; opsum_valid = 1; opsum_data = 64'h400; tick();
      opsum_valid = 0;
      set_info = 1; connect_flag = 1; tick();
      set_info = 1; connect_flag = 0; tick();
      set_info = 0;
      #1;
      chk("ovr_busy", cfg_busy, 1);
      opsum_bus_ready = 1; tick(); tick();
      #1;
      chk("ovr_busy_done", cfg_busy, 0);
      opsum_bus_ready = 0; opsum_valid = 1; opsum_data = 64'h401; tick();
      opsum_valid = 0;
      #1;
      chk("ovr_bus_obv", opsum_bus_valid, 1);
      chk("ovr_bus_ipv", ipsum_valid, 0);

      // Randomized traffic against a queue model.
      rst = 1; tick(); rst = 0;
      q.delete(); m_chain = 0; m_busy = 0; m_pend = 0;
      for (int c = 0; c < 600; c++) begin
         opsum_valid     = ($urandom_range(0, 3) != 0);
         opsum_data      = {$urandom, $urandom};
         ipsum_ready     = ($urandom_range(0, 2) != 0);
         opsum_bus_ready = ($urandom_range(0, 2) != 0);
         ipsum_bus_valid = $urandom_range(0, 1) != 0;
         ipsum_bus_data  = {$urandom, $urandom};
         set_info        = ($urandom_range(0, 11) == 0);
         connect_flag    = $urandom_range(0, 1) != 0;
         #1;
         e_rdy = (q.size() < DEPTH) && !m_busy;
         chk("rnd_count", fifo_count, 64'(q.size()));
         chk("rnd_busy", cfg_busy, m_busy);
         chk("rnd_ordy", opsum_ready, e_rdy);
         if (m_chain) begin
            chk("rnd_ipv", ipsum_valid, q.size() != 0);
            chk("rnd_ipd", ipsum_data, (q.size() != 0) ? q[0] : 64'h0);
            chk("rnd_obv", opsum_bus_valid, 0);
            chk("rnd_obd", opsum_bus_data, 0);
            chk("rnd_ibr", ipsum_bus_ready, 0);
         end else begin
            chk("rnd_ipv", ipsum_valid, ipsum_bus_valid);
            chk("rnd_ipd", ipsum_data, ipsum_bus_valid ? ipsum_bus_data : 64'h0);
            chk("rnd_obv", opsum_bus_valid, q.size() != 0);
            chk("rnd_obd", opsum_bus_data, (q.size() != 0) ? q[0] : 64'h0);
            chk("rnd_ibr", ipsum_bus_ready, ipsum_ready);
         end
         do_push = opsum_valid && e_rdy;
         do_pop  = (q.size() != 0) && (m_chain ? ipsum_ready : opsum_bus_ready);
         sz0 = q.size();
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(opsum_data);
         if (set_info) begin
            m_pend = connect_flag;
            m_busy = 1;
         end else if (m_busy && sz0 == 0) begin
            m_chain = m_pend;
            m_busy  = 0;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ln_router.md
LN_ROUTER -- requirements
Module: ln_router

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, bit width of one psum.
REQ-002 SHALL have parameter PSUM_NUM, default 4, psums per transfer; all psum buses are PSUM_NUM*DATA_SIZE bits.
REQ-003 SHALL have parameter DEPTH, default 4, opsum FIFO entries, power of two, at least 2.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset.
REQ-005 SHALL use one clock, clk; rst is asynchronous and active-high.
REQ-006 SHALL have ports: set_info  in  1  config strobe; connect_flag  in  1  requested mode (1=CHAIN, 0=BUS); cfg_busy  out  1  config pending.
REQ-007 SHALL have ports: opsum_data  in  PSUM_NUM*DATA_SIZE  psum from local PE; opsum_valid  in  1; opsum_ready  out  1.
REQ-008 SHALL have ports: ipsum_data  out  PSUM_NUM*DATA_SIZE  psum to PE; ipsum_valid  out  1; ipsum_ready  in  1.
REQ-009 SHALL have ports: ipsum_bus_data  in  PSUM_NUM*DATA_SIZE  psum from bus; ipsum_bus_valid  in  1; ipsum_bus_ready  out  1.
REQ-010 SHALL have ports: opsum_bus_data  out  PSUM_NUM*DATA_SIZE  psum to bus; opsum_bus_valid  out  1; opsum_bus_ready  in  1.
REQ-011 SHALL have port fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-012 SHALL transfer on any channel only on a cycle where valid and ready are both high.
REQ-013 SHALL push opsum_data into the FIFO on an opsum handshake; opsum_ready = !full && !cfg_busy.
REQ-014 SHALL present a pushed entry at the FIFO head no earlier than the cycle after the push (1-cycle minimum latency, no combinational opsum-to-output path).
REQ-015 SHALL, in CHAIN mode, drive ipsum_valid = !empty and ipsum_data = head, pop on ipsum_ready, and hold opsum_bus_valid=0 and ipsum_bus_ready=0.
REQ-016 SHALL, in BUS mode, drive opsum_bus_valid = !empty and opsum_bus_data = head, pop on opsum_bus_ready, and pass ipsum_bus_data/valid combinationally to ipsum_data/valid with ipsum_bus_ready = ipsum_ready.
REQ-017 SHALL drive every outgoing psum data bus to zero while its valid is low.
REQ-018 SHALL, when full, deassert opsum_ready even if a pop occurs in the same cycle; when empty, a same-cycle push SHALL NOT be popped that cycle.
REQ-019 SHALL, on simultaneous push and pop when neither full nor empty, keep fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 SHALL, on set_info, register connect_flag as the pending mode and raise cfg_busy the next cycle; a push in the set_info cycle itself is allowed.
REQ-021 SHALL, while cfg_busy and fifo_count==0, load the pending mode and clear cfg_busy at that clock edge; the new mode applies from the following cycle.
REQ-022 SHALL, on set_info while cfg_busy, overwrite the pending mode without clearing cfg_busy.
REQ-023 SHALL drain all entries already in the FIFO under the old mode before the mode changes.

Reset
REQ-024 SHALL, on rst, clear immediately: mode=BUS, cfg_busy=0, pointers=0, fifo_count=0, FIFO-driven valids=0; FIFO payload SHALL NOT be reset.
REQ-025 SHALL, on rst asserted mid-transfer, discard all FIFO contents and any pending config.

Structure
REQ-026 SHALL take mode encoding (BUS=0, CHAIN=1) and default DATA_SIZE/PSUM_NUM from shared package ln_pkg.
REQ-027 SHALL implement buffering in sub-module ln_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-028 SHALL test: after reset, BUS mode; push A=0x0001_0002_0003_0004 with opsum_bus_ready=1 -> opsum_bus_valid with A exactly 1 cycle later; ipsum_valid stays 0 from the FIFO.
REQ-029 SHALL test: BUS mode, ipsum_bus_valid=1 with data 0x55, ipsum_ready=0 -> ipsum_valid=1 and data 0x55 the same cycle, ipsum_bus_ready=0.
REQ-030 SHALL test: DEPTH=4, opsum_bus_ready=0, 5 pushes attempted -> 4 accepted, fifo_count=4, opsum_ready=0; then drain -> 4 outputs in order.
REQ-031 SHALL test: 2 entries queued in BUS, set_info with connect_flag=1 -> cfg_busy=1 and opsum_ready=0 until both drain to the bus; mode becomes CHAIN the cycle after empty and the next push appears on ipsum.
REQ-032 SHALL test: set_info(1) then set_info(0) while cfg_busy -> mode stays BUS after the drain.
REQ-033 SHALL test: rst asserted with 3 entries queued -> fifo_count=0 and all valids 0 without a clock edge.
